// File: rtl/controle_busca.sv
// Fetch sequencer and port arbiter for a 256x8 instruction memory: the loader owns
// the port while idle, the program counter owns it while running fetch/execute.
module controle_busca #(
  parameter logic [7:0] PC_INICIAL = 8'd0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Iniciar,
  input  logic       Carga_Req,
  input  logic [7:0] Carga_End,
  input  logic [7:0] Carga_Dado,
  output logic       Carga_Ack,
  output logic [7:0] Mem_End,
  output logic [7:0] Mem_Dado_Esc,
  output logic       Mem_Esc,
  input  logic [7:0] Mem_Saida,
  input  logic       Desvio,
  input  logic [7:0] Desvio_Alvo,
  input  logic       Halt,
  output logic [7:0] Instr,
  output logic       Instr_Valida,
  output logic [7:0] PC,
  output logic [1:0] Estado,
  output logic       Parado,
  output logic [8:0] Contagem
);

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    BUSCA  = 2'b01,
    EXEC   = 2'b10,
    PARADO = 2'b11
  } estado_t;

  estado_t    estado_q;
  logic [7:0] pc_q;
  logic [7:0] instr_q;
  logic [8:0] contagem_q;
  logic [8:0] contagem_d;

  function automatic logic [8:0] sat_inc(input logic [8:0] c);
    return (c == 9'd256) ? c : c + 9'd1;
  endfunction

  assign contagem_d = sat_inc(contagem_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q   <= OCIOSO;
      pc_q       <= PC_INICIAL;
      instr_q    <= 8'd0;
      contagem_q <= 9'd0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          // A pending write beats a start; the requester keeps Iniciar held.
          if (Carga_Req) begin
            contagem_q <= contagem_d;
          end else if (Iniciar) begin
            pc_q       <= PC_INICIAL;
            contagem_q <= 9'd0;
            estado_q   <= BUSCA;
          end
        end
        BUSCA: begin
          instr_q  <= Mem_Saida;
          estado_q <= EXEC;
        end
        EXEC: begin
          if (Halt) begin
            estado_q <= PARADO;
          end else if (Desvio) begin
            pc_q     <= Desvio_Alvo;
            estado_q <= BUSCA;
          end else begin
            pc_q     <= pc_q + 8'd1;
            estado_q <= BUSCA;
          end
        end
        PARADO: begin
          // Handing back to the loader costs one unacked cycle.
          if (Carga_Req) begin
            estado_q <= OCIOSO;
          end else if (Iniciar) begin
            pc_q       <= PC_INICIAL;
            contagem_q <= 9'd0;
            estado_q   <= BUSCA;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign Carga_Ack    = (estado_q == OCIOSO) && Carga_Req;
  assign Mem_Esc      = Carga_Ack;
  assign Mem_End      = (estado_q == OCIOSO) ? Carga_End : pc_q;
  assign Mem_Dado_Esc = Carga_Dado;
  assign Instr        = instr_q;
  assign Instr_Valida = (estado_q == EXEC);
  assign PC           = pc_q;
  assign Estado       = estado_q;
  assign Parado       = (estado_q == PARADO);
  assign Contagem     = contagem_q;

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
- Fetch sequencer and port arbiter for the 256x8 instruction memory, which has a combinational read and a synchronous write.
- Gives the memory port to an external program loader while idle. In run mode the port belongs to the program counter.
- Runs a two-cycle fetch/execute loop: PC drives the memory address, the fetched word is held in an instruction register, and redirect/halt from the datapath are applied each loop.

Parameters:
- PC_INICIAL, 8'd0, PC value loaded at reset and on every start.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Iniciar  in  1  start/restart request, level-sampled.
- Carga_Req  in  1  loader write request.
- Carga_End  in  8  loader write address.
- Carga_Dado  in  8  loader write data.
- Carga_Ack  out  1  write accepted this cycle (combinational).
- Mem_End  out  8  instruction memory address.
- Mem_Dado_Esc  out  8  instruction memory write data.
- Mem_Esc  out  1  instruction memory write enable.
- Mem_Saida  in  8  instruction memory read data.
- Desvio  in  1  redirect taken, from datapath (valid in EXEC).
- Desvio_Alvo  in  8  redirect target address.
- Halt  in  1  halt decoded by datapath (valid in EXEC).
- Instr  out  8  instruction register.
- Instr_Valida  out  1  high during EXEC; Instr is stable.
- PC  out  8  program counter.
- Estado  out  2  state code.
- Parado  out  1  high in PARADO.
- Contagem  out  9  words written since last start, saturates at 256.

Behaviour:
- Reset (async, Reset=0):
  - Estado=OCIOSO, PC=PC_INICIAL, Instr=0, Contagem=0.
  - All outputs are derived from these registers, so Instr_Valida=0 and Parado=0.
  - Reset mid-fetch aborts immediately; no pending write completes.
- States and encodings: OCIOSO=00, BUSCA=01, EXEC=10, PARADO=11.
- OCIOSO (loader owns the port):
  - Mem_End=Carga_End, Mem_Dado_Esc=Carga_Dado.
  - Mem_Esc = Carga_Ack = Carga_Req. One word is written per cycle the request is high.
  - Contagem increments per accepted write and saturates at 256.
  - Iniciar=1 with Carga_Req=0: PC<=PC_INICIAL, Contagem<=0, go to BUSCA.
  - Iniciar=1 with Carga_Req=1: the write wins; stay in OCIOSO and drop the start (requester holds Iniciar).
- BUSCA:
  - Mem_End=PC, Mem_Esc=0.
  - At the edge: Instr<=Mem_Saida, go to EXEC.
- EXEC:
  - Instr_Valida=1, Mem_End=PC, Mem_Esc=0.
  - At the edge, in priority order:
    - Halt=1: PC holds, go to PARADO (Halt beats Desvio).
    - Desvio=1: PC<=Desvio_Alvo, go to BUSCA.
    - Otherwise: PC<=PC+1 modulo 256 (255 wraps to 0), go to BUSCA.
- PARADO:
  - Parado=1, PC and Instr hold, Mem_End=PC, Mem_Esc=0.
  - Carga_Req=1: go to OCIOSO. No write and no ack this cycle; the loader's held request is accepted next cycle.
  - Otherwise Iniciar=1: PC<=PC_INICIAL, Contagem<=0, go to BUSCA.
  - Carga_Req has priority over Iniciar.
- Loader arbitration outside OCIOSO:
  - In BUSCA/EXEC/PARADO, Carga_Ack=0 and Mem_Esc=0.
  - The loader holds Carga_Req/Carga_End/Carga_Dado until acked.
- Iniciar in BUSCA/EXEC is ignored.
- Throughput: exactly 2 cycles per instruction; Instr_Valida never high on consecutive cycles.
- Mem_Dado_Esc equals Carga_Dado in all states; it is qualified only by Mem_Esc.

Test Plan:
- Load sequence: reset, then Carga_Req for 3 cycles at addresses 0,1,2 with data 8'h8D,8'h89,8'hE0 -> Carga_Ack=Mem_Esc=1 for those 3 cycles, Contagem=3, Estado stays 00.
- Sequential fetch: Iniciar, memory holds 8'h8D,8'h89,8'h81 -> Instr sequence 8D,89,81; PC 0,1,2; Instr_Valida pulses every 2nd cycle.
- Redirect: Desvio=1 with Desvio_Alvo=8'd19 in EXEC at PC=16 -> next BUSCA has Mem_End=19. Halt=1 in the same cycle as Desvio=1 -> PARADO, PC holds 16.
- Wrap: PC=255 in EXEC, no Desvio/Halt -> PC=0.
- Arbitration: Carga_Req held from PARADO -> Estado 11->00 with no ack, then Carga_Ack=1 the next cycle. Carga_Req with Iniciar in OCIOSO -> write occurs, Estado stays 00. Carga_Req during EXEC -> Carga_Ack=0, Mem_Esc=0.
- Async reset asserted mid-EXEC -> Estado=00, PC=PC_INICIAL, Instr=0 without waiting for a clock edge.
